// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART receive/interrupt controller:
// IIR source IDs, FCR bit positions and the RX trigger-level decode.
package uart_pkg;

    localparam logic [3:0] IIR_RLS  = 4'b0110;
    localparam logic [3:0] IIR_RDA  = 4'b0100;
    localparam logic [3:0] IIR_CTO  = 4'b1100;
    localparam logic [3:0] IIR_THRE = 4'b0010;
    localparam logic [3:0] IIR_MSI  = 4'b0000;
    localparam logic [3:0] IIR_NONE = 4'b0001;

    localparam int FCR_FIFO_EN = 0;
    localparam int FCR_RX_CLR  = 1;
    localparam int FCR_TX_CLR  = 2;
    localparam int FCR_TRIG_LO = 6;
    localparam int FCR_TRIG_HI = 7;

    function automatic logic [3:0] trig_decode(input logic [1:0] sel);
        logic [3:0] lvl;
        case (sel)
            2'b00:   lvl = 4'd1;
            2'b01:   lvl = 4'd4;
            2'b10:   lvl = 4'd8;
            default: lvl = 4'd14;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// 16550-style character-timeout counter; saturates at the idle limit and
// raises a sticky timeout_pend until the FIFO is read, emptied or cleared.
module uart_rx_timeout
    import uart_pkg::*;
#(
    parameter int CNT_W          = 6,
    parameter int TICKS_PER_CHAR = 160,
    parameter int TIMEOUT_CHARS  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_en,
    input  logic [CNT_W-1:0] rx_count,
    input  logic             rx_push,
    input  logic             rx_pop,
    input  logic             rx_clr,
    input  logic             baud_tick,
    output logic             timeout_pend
);

    localparam int LIMIT = TICKS_PER_CHAR * TIMEOUT_CHARS;
    localparam int TO_W  = $clog2(LIMIT + 1);

    logic [TO_W-1:0] cnt;
    logic            rx_empty;

    assign rx_empty = (rx_count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            timeout_pend <= 1'b0;
        end else begin
            if (rx_push || rx_pop || rx_empty || !fifo_en)
                cnt <= '0;
            else if (baud_tick && cnt != TO_W'(LIMIT))
                cnt <= cnt + TO_W'(1);

            // Clearing takes precedence: a pop always restarts the idle window.
            if (rx_pop || rx_empty || rx_clr)
                timeout_pend <= 1'b0;
            else if (cnt == TO_W'(LIMIT))
                timeout_pend <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_irq_ctrl.sv
// UART RX controller: FCR decode, character timeout and prioritised IIR/irq.
// Optional modem-status interrupt source enabled by defining UART_MSR_IRQ_EN.
module uart_rx_irq_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH     = 32,
    parameter int CNT_W          = 6,
    parameter int TICKS_PER_CHAR = 160,
    parameter int TIMEOUT_CHARS  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fcr_wr,
    input  logic [7:0]       fcr_wdata,
    input  logic [3:0]       ier,
    input  logic [CNT_W-1:0] rx_count,
    input  logic             rx_push,
    input  logic             rx_pop,
    input  logic [3:0]       lsr_err,
    input  logic             thr_empty,
    input  logic             iir_rd,
    input  logic             baud_tick,
`ifdef UART_MSR_IRQ_EN
    input  logic [3:0]       msr_delta,
`endif
    output logic             fifo_en,
    output logic             rx_fifo_clr,
    output logic             tx_fifo_clr,
    output logic [CNT_W-1:0] trig_level,
    output logic [7:0]       iir,
    output logic             irq
);

    if ((1 << CNT_W) <= FIFO_DEPTH) begin : g_cnt_w_check
        $error("CNT_W too narrow for FIFO_DEPTH");
    end

    logic       fifo_en_next;
    logic       mode_chg;
    logic       timeout_pend;
    logic       thre_pend;
    logic       thr_empty_q;
    logic       ier_thre_q;
    logic       thre_set;
    logic       thre_clr;
    logic       rda;
    logic [3:0] id;

    assign fifo_en_next = fcr_wr ? fcr_wdata[FCR_FIFO_EN] : fifo_en;
    assign mode_chg     = fcr_wr && (fcr_wdata[FCR_FIFO_EN] != fifo_en);

    // Clear pulses are suppressed while one is already high, so back-to-back
    // FCR writes can never stretch a pulse past one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_en     <= 1'b0;
            rx_fifo_clr <= 1'b0;
            tx_fifo_clr <= 1'b0;
            trig_level  <= CNT_W'(1);
        end else begin
            fifo_en     <= fifo_en_next;
            rx_fifo_clr <= fcr_wr && !rx_fifo_clr && (fcr_wdata[FCR_RX_CLR] || mode_chg);
            tx_fifo_clr <= fcr_wr && !tx_fifo_clr && (fcr_wdata[FCR_TX_CLR] || mode_chg);
            if (fcr_wr)
                trig_level <= CNT_W'(trig_decode(fcr_wdata[FCR_TRIG_HI:FCR_TRIG_LO]));
        end
    end

    uart_rx_timeout #(
        .CNT_W          (CNT_W),
        .TICKS_PER_CHAR (TICKS_PER_CHAR),
        .TIMEOUT_CHARS  (TIMEOUT_CHARS)
    ) u_timeout (
        .clk          (clk),
        .reset        (reset),
        .fifo_en      (fifo_en),
        .rx_count     (rx_count),
        .rx_push      (rx_push),
        .rx_pop       (rx_pop),
        .rx_clr       (rx_fifo_clr),
        .baud_tick    (baud_tick),
        .timeout_pend (timeout_pend)
    );

    // Edge trackers follow their inputs through reset so no false edge is seen after it.
    always_ff @(posedge clk) begin
        thr_empty_q <= thr_empty;
        ier_thre_q  <= ier[1];
    end

    assign thre_set = (thr_empty && !thr_empty_q) || (ier[1] && !ier_thre_q && thr_empty);
    assign thre_clr = (iir_rd && iir[3:0] == IIR_THRE) || !thr_empty;

    always_ff @(posedge clk) begin
        if (reset)
            thre_pend <= 1'b0;
        else if (thre_set)
            thre_pend <= 1'b1;
        else if (thre_clr)
            thre_pend <= 1'b0;
    end

    assign rda = fifo_en ? (rx_count >= trig_level) : (rx_count != '0);

    always_comb begin
        id = IIR_NONE;
        if (ier[2] && |lsr_err)
            id = IIR_RLS;
        else if (ier[0] && rda)
            id = IIR_RDA;
        else if (ier[0] && timeout_pend)
            id = IIR_CTO;
        else if (ier[1] && thre_pend)
            id = IIR_THRE;
`ifdef UART_MSR_IRQ_EN
        else if (ier[3] && |msr_delta)
            id = IIR_MSI;
`endif
    end

`ifndef UART_MSR_IRQ_EN
    logic unused_ier3;
    assign unused_ier3 = ier[3];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            iir <= 8'h01;
            irq <= 1'b0;
        end else begin
            iir <= {(fifo_en_next ? 2'b11 : 2'b00), 2'b00, id};
            irq <= !id[0];
        end
    end

endmodule

// File: doc/uart_rx_irq_ctrl.md
Name: uart_rx_irq_ctrl

Overview:
- Controller for the UART receive path and the interrupt identification logic.
- Decodes FCR writes into FIFO enable, clear pulses and the RX trigger level.
- Runs the 16550-style character-timeout counter.
- Arbitrates pending interrupt sources by fixed priority into a registered IIR value and an irq line to the APB side.

Parameters:
- FIFO_DEPTH, 32, receive FIFO depth; occupancy range 0..FIFO_DEPTH.
- CNT_W, 6, width of the occupancy count; must satisfy 2^CNT_W > FIFO_DEPTH.
- TICKS_PER_CHAR, 160, baud_tick pulses per character (16x oversample × 10 bits).
- TIMEOUT_CHARS, 4, character times of RX idle before a timeout interrupt.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fcr_wr  in  1  FCR write strobe, one cycle
- fcr_wdata  in  8  FCR write data
- ier  in  4  interrupt enables {MSI,RLS,THRE,RDA}
- rx_count  in  CNT_W  current RX FIFO occupancy
- rx_push  in  1  received character written to FIFO
- rx_pop  in  1  RBR read by processor
- lsr_err  in  4  sticky line errors {BI,FE,PE,OE}
- thr_empty  in  1  transmit holding register/FIFO empty (level)
- iir_rd  in  1  IIR read strobe
- baud_tick  in  1  16x oversample tick
- fifo_en  out  1  FIFO mode enable (FCR[0])
- rx_fifo_clr  out  1  one-cycle RX FIFO clear pulse
- tx_fifo_clr  out  1  one-cycle TX FIFO clear pulse
- trig_level  out  CNT_W  RDA trigger threshold
- iir  out  8  interrupt identification value
- irq  out  1  interrupt request, active high

Behaviour:
Reset (clk edge with reset=1) sets all outputs as follows:
- fifo_en=0, clear pulses=0, trig_level=1.
- iir=8'h01, irq=0.
- Timeout counter=0, timeout_pend=0, thre_pend=0.

FCR decode: on fcr_wr, registered next cycle:
- fifo_en <= fcr_wdata[0].
- trig_level from fcr_wdata[7:6]: 00→1, 01→4, 10→8, 11→14.
- rx_fifo_clr pulses one cycle if fcr_wdata[1]=1 OR fcr_wdata[0] differs from the current fifo_en.
- tx_fifo_clr pulses under the same rule, using fcr_wdata[2].
- Clear pulses never exceed one cycle, even for back-to-back writes.

Timeout counter (width ceil(log2(TICKS_PER_CHAR*TIMEOUT_CHARS+1))):
- Zeroed when any of these holds: rx_push, rx_pop, rx_count==0, or fifo_en==0.
- Otherwise increments on baud_tick.
- At TICKS_PER_CHAR*TIMEOUT_CHARS it sets timeout_pend and holds (saturates).
- timeout_pend clears on rx_pop, rx_count==0, or an RX clear pulse.

THRE pending:
- Set on a 0→1 edge of thr_empty, or on ier[1] rising while thr_empty=1.
- Cleared on iir_rd while iir[3:0]==4'b0010, or when thr_empty=0.
- If set and clear fall in the same cycle, set wins.

Priority (highest first); iir[3:0] encodings:
1. RLS: ier[2] & |lsr_err → 0110.
2. RDA: ier[0] & (fifo_en ? rx_count>=trig_level : rx_count!=0) → 0100.
3. Timeout: ier[0] & timeout_pend → 1100.
4. THRE: ier[1] & thre_pend → 0010.
5. None → 0001.

Output register rules:
- iir[5:4]=0; iir[7:6]=fifo_en ? 2'b11 : 2'b00.
- iir and irq are registered with 1-cycle latency from their inputs.
- irq = (iir[0]==0), updated in the same cycle as iir.
- Clearing ier bits removes the corresponding source on the next cycle. Pending flags are retained, except that thre_pend is re-armed only via the rules above.

Optional Feature:
UART_MSR_IRQ_EN:
- When defined: adds input msr_delta[3:0]. Source 5 = ier[3] & |msr_delta → iir[3:0]=0000, lowest priority.
- When undefined: the port is absent, ier[3] is ignored, and the none case remains 0001.

Decomposition:
- Package uart_pkg holds:
  - IIR ID constants (IIR_RLS, IIR_RDA, IIR_CTO, IIR_THRE, IIR_MSI, IIR_NONE).
  - The trigger-level encoding function.
  - FCR bit index constants.
- One sub-module, uart_rx_timeout: the timeout counter plus timeout_pend.

Test Plan:
1. Reset, then fcr_wr with 8'hC7 → next cycle fifo_en=1, trig_level=14, rx_fifo_clr and tx_fifo_clr each high exactly 1 cycle, iir=8'hC1.
2. fifo_en=1, trig_level=4, ier=4'b0001; rx_count driven 3 then 4 → irq stays 0 at 3; iir=8'hC4 and irq=1 one cycle after rx_count=4.
3. rx_count=2, trig_level=8, ier[0]=1, no push/pop for 640 baud_ticks → iir=8'hCC. A single rx_pop then clears it within 1 cycle.
4. ier=4'b0111, rx_count=14, trig_level=14, lsr_err=4'b0001 → iir[3:0]=0110. Clearing lsr_err → 0100.
5. ier[1]=1 and thr_empty rises → iir[3:0]=0010; iir_rd → 0001 next cycle. thr_empty rising in the same cycle as iir_rd → stays 0010.
6. Timeout counter at 600 ticks, then reset asserted → all outputs at reset values the next cycle, and 640 further ticks are required before a timeout.
